// File: rtl/conversor_dho_bin_pkg.sv
// Shared definitions for the DEC/HEX/OCT to binary converter.
package conversor_dho_bin_pkg;

  localparam logic [1:0] SEL_DEC = 2'b01;
  localparam logic [1:0] SEL_HEX = 2'b10;
  localparam logic [1:0] SEL_OCT = 2'b11;

  localparam int unsigned DEC_ITER = 10;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/subsel3.sv
// BCD digit correction step for reverse double dabble: subtract 3 when digit >= 8.
module subsel3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/conversor_dho_bin.sv
// Three-digit Dec/Hex/Oct to 8-bit binary converter; Dec uses iterative reverse double dabble.
module conversor_dho_bin
  import conversor_dho_bin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [3:0] C,
  input  logic [3:0] D,
  input  logic [3:0] U,
  output logic       busy,
  output logic       done,
  output logic [7:0] B,
  output logic       erro
);

  localparam logic [3:0] LastIter = 4'(DEC_ITER - 1);

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dig_err_q, dig_err_d;
  logic [7:0]  b_q, b_d;
  logic        erro_q, erro_d;

  logic [11:0] bcd_shift, bcd_iter;
  logic [9:0]  acc_shift;
  logic        dec_err;

  // One iteration: shift {bcd, acc} right, then correct each BCD digit.
  assign bcd_shift = {1'b0, bcd_q[11:1]};
  assign acc_shift = {bcd_q[0], acc_q[9:1]};

  subsel3 u_sub_c (.din(bcd_shift[11:8]), .dout(bcd_iter[11:8]));
  subsel3 u_sub_d (.din(bcd_shift[7:4]),  .dout(bcd_iter[7:4]));
  subsel3 u_sub_u (.din(bcd_shift[3:0]),  .dout(bcd_iter[3:0]));

  assign dec_err = dig_err_q | (acc_shift[9:8] != 2'b00);

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dig_err_d = dig_err_q;
    b_d       = b_q;
    erro_d    = erro_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d     = {C, D, U};
          acc_d     = '0;
          cnt_d     = '0;
          dig_err_d = (C > 4'd9) | (D > 4'd9) | (U > 4'd9);
          if (sel == SEL_DEC) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            case (sel)
              SEL_HEX: begin
                erro_d = (C != 4'd0);
                b_d    = (C != 4'd0) ? 8'h00 : {D, U};
              end
              SEL_OCT: begin
                erro_d = (C > 4'd3) | (D > 4'd7) | (U > 4'd7);
                b_d    = ((C > 4'd3) | (D > 4'd7) | (U > 4'd7)) ? 8'h00
                                                                : {C[1:0], D[2:0], U[2:0]};
              end
              default: begin
                erro_d = 1'b1;
                b_d    = 8'h00;
              end
            endcase
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_iter;
        acc_d = acc_shift;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LastIter) begin
          state_d = DONE;
          erro_d  = dec_err;
          b_d     = dec_err ? 8'h00 : acc_shift[7:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dig_err_q <= 1'b0;
      b_q       <= 8'h00;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dig_err_q <= dig_err_d;
      b_q       <= b_d;
      erro_q    <= erro_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign B    = b_q;
  assign erro = erro_q;

endmodule

// File: tb/tb_conversor_dho_bin.sv
// Directed self-checking bench for conversor_dho_bin.
module tb_conversor_dho_bin;
  import conversor_dho_bin_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] C = 4'd0, D = 4'd0, U = 4'd0;
  logic       busy, done, erro;
  logic [7:0] B;

  int errors = 0;
  int checks = 0;

  conversor_dho_bin dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel),
    .C(C), .D(D), .U(U),
    .busy(busy), .done(done), .B(B), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one conversion on the next edge, then scramble inputs to prove they were captured.
  task automatic launch(input logic [1:0] s, input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] u);
    sel = s; C = c; D = d; U = u; start = 1'b1;
    tick();
    start = 1'b0; sel = 2'b00; C = 4'hF; D = 4'hE; U = 4'hD;
  endtask

  // Samples since the accepting edge until done is seen (1 = cycle right after it).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL rst_b: got %h want 00", B); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL rst_erro: got %b want 0", erro); end
    // First edge with rst_n high must already accept start.
    rst_n = 1'b1; sel = SEL_HEX; C = 4'd0; D = 4'd1; U = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_start_done: got %b want 1", done); end
    checks++; if (B !== 8'h12) begin errors++; $display("FAIL first_start_b: got %h want 12", B); end
    tick();
  endtask

  task automatic test_dec();
    int cyc;
    launch(SEL_DEC, 4'd2, 4'd5, 4'd5);
    for (int i = 1; i <= 11; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL dec_busy_%0d: got %b want 1", i, busy); end
      checks++;
      if (done !== (i == 11)) begin
        errors++; $display("FAIL dec_done_%0d: got %b want %b", i, done, (i == 11));
      end
      if (i < 11) tick();
    end
    checks++; if (B !== 8'hFF) begin errors++; $display("FAIL dec255_b: got %h want ff", B); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL dec255_erro: got %b want 0", erro); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_idle_busy: got %b want 0", busy); end

    launch(SEL_DEC, 4'd2, 4'd5, 4'd6);
    wait_done(cyc);
    checks++; if (cyc != 11) begin errors++; $display("FAIL dec256_lat: got %0d want 11", cyc); end
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL dec256_erro: got %b want 1", erro); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL dec256_b: got %h want 00", B); end
    tick();

    launch(SEL_DEC, 4'd0, 4'hA, 4'd0);
    wait_done(cyc);
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL dec_digit_erro: got %b want 1", erro); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL dec_digit_b: got %h want 00", B); end
    tick();

    launch(SEL_DEC, 4'd0, 4'd1, 4'd0);
    wait_done(cyc);
    checks++; if (B !== 8'h0A) begin errors++; $display("FAIL dec10_b: got %h want 0a", B); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL dec10_erro: got %b want 0", erro); end
    tick();
  endtask

  task automatic test_hex();
    int cyc;
    launch(SEL_HEX, 4'd0, 4'hA, 4'd5);
    wait_done(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL hex_lat: got %0d want 1", cyc); end
    checks++; if (B !== 8'hA5) begin errors++; $display("FAIL hex_b: got %h want a5", B); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL hex_erro: got %b want 0", erro); end
    repeat (3) tick();
    checks++; if (B !== 8'hA5) begin errors++; $display("FAIL hex_hold_b: got %h want a5", B); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hex_pulse: got %b want 0", done); end

    launch(SEL_HEX, 4'd1, 4'hA, 4'd5);
    wait_done(cyc);
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL hexc1_erro: got %b want 1", erro); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL hexc1_b: got %h want 00", B); end
    tick();
  endtask

  task automatic test_oct();
    int cyc;
    launch(SEL_OCT, 4'd3, 4'd7, 4'd7);
    wait_done(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL oct_lat: got %0d want 1", cyc); end
    checks++; if (B !== 8'hFF) begin errors++; $display("FAIL oct377_b: got %h want ff", B); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL oct377_erro: got %b want 0", erro); end
    tick();

    launch(SEL_OCT, 4'd4, 4'd0, 4'd0);
    wait_done(cyc);
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL octc4_erro: got %b want 1", erro); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL octc4_b: got %h want 00", B); end
    tick();

    launch(SEL_OCT, 4'd0, 4'd2, 4'd5);
    wait_done(cyc);
    checks++; if (B !== 8'h15) begin errors++; $display("FAIL oct025_b: got %h want 15", B); end
    tick();

    launch(SEL_OCT, 4'd0, 4'd0, 4'd8);
    wait_done(cyc);
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL octu8_erro: got %b want 1", erro); end
    tick();
  endtask

  task automatic test_invalid_sel();
    int cyc;
    launch(2'b00, 4'd0, 4'd1, 4'd2);
    wait_done(cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL sel00_lat: got %0d want 1", cyc); end
    checks++; if (erro !== 1'b1) begin errors++; $display("FAIL sel00_erro: got %b want 1", erro); end
    checks++; if (B !== 8'h00) begin errors++; $display("FAIL sel00_b: got %h want 00", B); end
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc;
    launch(SEL_DEC, 4'd2, 4'd5, 4'd5);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    checks++; if (erro !== 1'b0) begin errors++; $display("FAIL abort_erro: got %b want 0", erro); end
    rst_n = 1'b1;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_nodone: got %b want 0", done); end
    launch(SEL_DEC, 4'd1, 4'd2, 4'd8);
    wait_done(cyc);
    checks++; if (cyc != 11) begin errors++; $display("FAIL abort_new_lat: got %0d want 11", cyc); end
    checks++; if (B !== 8'h80) begin errors++; $display("FAIL abort_new_b: got %h want 80", B); end
    tick();
  endtask

  task automatic test_ignore_start();
    int nd = 0;
    int at = 0;
    logic [7:0] bv = 8'h00;
    launch(SEL_DEC, 4'd1, 4'd0, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      if (done === 1'b1) begin nd++; at = i; bv = B; end
      if (i == 3) begin start = 1'b1; sel = SEL_HEX; C = 4'd0; D = 4'hF; U = 4'hF; end
      if (i == 4) start = 1'b0;
      tick();
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_count: got %0d want 1", nd); end
    checks++; if (at != 11) begin errors++; $display("FAIL ignore_at: got %0d want 11", at); end
    checks++; if (bv !== 8'h64) begin errors++; $display("FAIL ignore_b: got %h want 64", bv); end
  endtask

  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    logic [7:0] bv = 8'h00;
    sel = SEL_DEC; C = 4'd0; D = 4'd4; U = 4'd2; start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
        bv = B;
      end
    end
    start = 1'b0;
    repeat (15) tick();
    checks++; if (second - first != 12) begin
      errors++; $display("FAIL b2b_dec_spacing: got %0d want 12", second - first);
    end
    checks++; if (bv !== 8'h2A) begin errors++; $display("FAIL b2b_dec_b: got %h want 2a", bv); end

    first = 0; second = 0; bv = 8'h00;
    sel = SEL_HEX; C = 4'd0; D = 4'd3; U = 4'hC; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (done === 1'b1) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
        bv = B;
      end
    end
    start = 1'b0;
    repeat (3) tick();
    checks++; if (second - first != 2) begin
      errors++; $display("FAIL b2b_hex_spacing: got %0d want 2", second - first);
    end
    checks++; if (bv !== 8'h3C) begin errors++; $display("FAIL b2b_hex_b: got %h want 3c", bv); end
  endtask

  initial begin
    test_reset();
    test_dec();
    test_hex();
    test_oct();
    test_reset_abort();
    test_invalid_sel();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conversor_dho_bin.md
CONVERSOR_DHO_BIN -- requirements
Module: conversor_dho_bin

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, active-low, synchronous to clk.
REQ-004 start  in  1  conversion request; sampled only in IDLE.
REQ-005 sel  in  2  entry base: 01=Dec, 10=Hex, 11=Oct, 00=invalid.
REQ-006 C  in  4  most significant digit (centena).
REQ-007 D  in  4  middle digit (dezena).
REQ-008 U  in  4  least significant digit (unidade).
REQ-009 busy  out  1  high whenever state is not IDLE.
REQ-010 done  out  1  single-cycle pulse: result valid.
REQ-011 B  out  8  converted binary value.
REQ-012 erro  out  1  conversion rejected; qualified by done.

Function
REQ-013 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1: SHALL capture C/D/U/sel into internal registers; later input changes are ignored until the next accepted start.
REQ-015 Dec accepted at edge k: SHALL enter SHIFT for exactly 10 cycles (k+1..k+10), then DONE at k+11.
REQ-016 Hex/Oct/sel=00 accepted at edge k: SHALL go directly to DONE at k+1.
REQ-017 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-018 Dec SHALL use reverse double dabble on a 12-bit BCD register {C,D,U} and a 10-bit binary accumulator, one iteration per SHIFT cycle.
REQ-019 Each Dec iteration SHALL shift {BCD,acc} right by 1, then subtract 3 from every BCD digit that is >=8.
REQ-020 Hex: B={D,U}; erro=1 if C!=0.
REQ-021 Oct: B={C[1:0],D[2:0],U[2:0]}; erro=1 if C>3, D>7 or U>7.
REQ-022 Dec: erro=1 if any digit >9 or acc>255.
REQ-023 sel=00: erro=1.
REQ-024 When erro=1, B SHALL be 8'h00.
REQ-025 B and erro SHALL update only on entry to DONE and hold until the next DONE.
REQ-026 start while busy=1 SHALL be ignored, with no queueing.
REQ-027 start held high SHALL begin a new conversion in the cycle after DONE (back-to-back).

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE with busy=0, done=0, B=8'h00, erro=0, and clear internal registers.
REQ-029 Reset during SHIFT or DONE SHALL abort the conversion; no done pulse SHALL follow.
REQ-030 The first start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-031 The shared package SHALL hold the sel encodings (SEL_DEC=01, SEL_HEX=10, SEL_OCT=11), the FSM state enum, and DEC_ITER=10.
REQ-032 A sub-module subsel3 (4-bit digit: out = in>=8 ? in-3 : in) SHALL be instantiated three times in the Dec datapath.
REQ-033 The implementation SHALL contain no combinational path from inputs to outputs.

Verification
REQ-034 Dec C=2,D=5,U=5, start at edge k -> busy k+1..k+11, done at k+11, B=8'hFF, erro=0.
REQ-035 Dec C=2,D=5,U=6 -> done at k+11, erro=1, B=8'h00; Dec C=0,D=A,U=0 -> erro=1.
REQ-036 Hex C=0,D=A,U=5 -> done at k+1, B=8'hA5; Hex C=1 -> erro=1, B=8'h00.
REQ-037 Oct C=3,D=7,U=7 -> B=8'hFF, erro=0; Oct C=4 -> erro=1; Oct U=8 -> erro=1.
REQ-038 Dec start, rst_n=0 at k+5 -> IDLE at k+6, busy=0, no done; a new start at k+7 converts correctly.
REQ-039 start pulsed at k+3 during Dec -> ignored, exactly one done; start held high -> consecutive conversions, done spacing 12 cycles (Dec) / 2 cycles (Hex).
